// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM state encoding and sizing helper.
package rf_pkg;

  localparam logic RF_IDLE  = 1'b0;
  localparam logic RF_CLEAR = 1'b1;

  function automatic int nreg(input int regbits);
    return 1 << regbits;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus between decode/writeback and the register file; the master drives addresses and write data.
interface reg_file_mp_if #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int NREAD   = 3
);
  logic                     clear_req;
  logic                     busy;
  logic                     we0;
  logic [REGBITS-1:0]       waddr0;
  logic [WIDTH-1:0]         wdata0;
  logic                     we1;
  logic [REGBITS-1:0]       waddr1;
  logic [WIDTH-1:0]         wdata1;
  logic [NREAD*REGBITS-1:0] raddr;
  logic [NREAD*WIDTH-1:0]   rdata;
  logic                     wr_conflict;
  logic                     clr_state;

  // No handshake: writes commit on any rising edge with weN high and busy low;
  // reads are combinational and valid in the same cycle their address is driven.
  modport master (
    output clear_req, we0, waddr0, wdata0, we1, waddr1, wdata1, raddr,
    input  busy, rdata, wr_conflict, clr_state
  );

  modport slave (
    input  clear_req, we0, waddr0, wdata0, we1, waddr1, wdata1, raddr,
    output busy, rdata, wr_conflict, clr_state
  );
endinterface

// File: rtl/reg_file_mp_clear_fsm.sv
// Sequential clear engine: sweeps every register to zero, one address per cycle.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int REGBITS      = 4,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_req,
  output logic               busy,
  output logic               clr_we,
  output logic [REGBITS-1:0] clr_addr,
  output logic               state_dbg
);

  localparam logic [REGBITS-1:0] LAST_ADDR = REGBITS'(nreg(REGBITS) - 1);

  logic               state_q, state_d;
  logic [REGBITS-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLR_ON_RESET ? RF_CLEAR : RF_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // The sweep leaves CLEAR on the same edge that zeroes the last register.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = '0;
    if (state_q == RF_IDLE) begin
      if (clear_req) state_d = RF_CLEAR;
    end else begin
      if (clr_addr_q == LAST_ADDR) state_d = RF_IDLE;
      else clr_addr_d = clr_addr_q + 1'b1;
    end
  end

  always_comb begin
    busy      = (state_q == RF_CLEAR);
    clr_we    = (state_q == RF_CLEAR);
    clr_addr  = clr_addr_q;
    state_dbg = state_q;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NREAD combinational reads with write bypass, two prioritised writes,
// and a hardware clear sweep.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int REGBITS      = 4,
  parameter int NREAD        = 3,
  parameter bit ZERO_R0      = 1'b1,
  parameter bit BYPASS       = 1'b1,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);

  localparam int NREG = nreg(REGBITS);

  logic [WIDTH-1:0]   mem_q [NREG];
  logic               busy, clr_we;
  logic [REGBITS-1:0] clr_addr;
  logic               we0_eff, we1_eff;
  logic               wr_conflict_q, wr_conflict_d;

  rf_clear_fsm #(
    .REGBITS      (REGBITS),
    .CLR_ON_RESET (CLR_ON_RESET)
  ) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear_req (bus.clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .state_dbg (bus.clr_state)
  );

  // Writes to a hardwired r0 are discarded before they can reach the RAM or the conflict flag.
  assign we0_eff = bus.we0 && !busy && !(ZERO_R0 && bus.waddr0 == '0);
  assign we1_eff = bus.we1 && !busy && !(ZERO_R0 && bus.waddr1 == '0);
  assign wr_conflict_d = we0_eff && we1_eff && (bus.waddr0 == bus.waddr1);

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (we0_eff) mem_q[bus.waddr0] <= bus.wdata0;
      if (we1_eff) mem_q[bus.waddr1] <= bus.wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wr_conflict_q <= 1'b0;
    else       wr_conflict_q <= wr_conflict_d;
  end

  assign bus.busy        = busy;
  assign bus.wr_conflict = wr_conflict_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [REGBITS-1:0] ra;
    logic [WIDTH-1:0]   rd;

    assign ra = bus.raddr[k*REGBITS +: REGBITS];

    always_comb begin
      rd = mem_q[ra];
      if (busy)                                       rd = '0;
      else if (ZERO_R0 && ra == '0)                   rd = '0;
      else if (BYPASS && bus.we1 && bus.waddr1 == ra) rd = bus.wdata1;
      else if (BYPASS && bus.we0 && bus.waddr0 == ra) rd = bus.wdata0;
    end

    assign bus.rdata[k*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default build plus a 4-read, plain-r0, no-bypass build driven in lockstep.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_mp_if #(.WIDTH(16), .REGBITS(4), .NREAD(3)) bus_a ();
  reg_file_mp_if #(.WIDTH(16), .REGBITS(4), .NREAD(4)) bus_b ();

  reg_file_mp #(.WIDTH(16), .REGBITS(4), .NREAD(3), .ZERO_R0(1'b1), .BYPASS(1'b1),
                .CLR_ON_RESET(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  reg_file_mp #(.WIDTH(16), .REGBITS(4), .NREAD(4), .ZERO_R0(1'b0), .BYPASS(1'b0),
                .CLR_ON_RESET(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  // ---------------- stimulus variables ----------------
  logic        rst_s, clr_s, we0_s, we1_s;
  logic [3:0]  a0_s, a1_s;
  logic [15:0] d0_s, d1_s;
  logic [3:0]  ra_s [4];

  // ---------------- reference model ----------------
  logic [15:0] mem_m [2][16];
  bit          mem_v [2][16];
  int          clr_left [2];
  bit          conf_m [2];
  bit          model_live = 1'b0;
  bit          cfg_zero [2] = '{1'b1, 1'b0};
  bit          cfg_byp  [2] = '{1'b1, 1'b0};
  bit          cfg_clr  [2] = '{1'b1, 1'b0};
  int          cfg_nread [2] = '{3, 4};

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q [$];
  int          tag_q [$];
  int          checks = 0;
  int          errors = 0;

  function automatic void push(input int tag, input logic [15:0] val);
    exp_q.push_back(val);
    tag_q.push_back(tag);
  endfunction

  function automatic logic [15:0] actual(input int tag);
    int d = tag / 16;
    int s = tag % 16;
    if (d == 0) begin
      if (s == 8) return {15'd0, bus_a.busy};
      if (s == 9) return {15'd0, bus_a.wr_conflict};
      return bus_a.rdata[s*16 +: 16];
    end
    if (s == 8) return {15'd0, bus_b.busy};
    if (s == 9) return {15'd0, bus_b.wr_conflict};
    return bus_b.rdata[s*16 +: 16];
  endfunction

  function automatic string tname(input int tag);
    int s = tag % 16;
    string dn = (tag / 16 == 0) ? "dut_a" : "dut_b";
    if (s == 8) return {dn, ".busy"};
    if (s == 9) return {dn, ".wr_conflict"};
    return $sformatf("%s.rdata%0d", dn, s);
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      logic [15:0] a;
      int t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = actual(t);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s got %h expected %h (t=%0t)", tname(t), a, e, $time);
      end
    end
  end

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference read: returns validity through 'known' so uninitialised registers are not checked.
  function automatic logic [15:0] model_read(input int d, input logic [3:0] ra, output bit known);
    known = 1'b1;
    if (clr_left[d] > 0)                   return 16'h0;
    if (cfg_zero[d] && ra == 4'd0)         return 16'h0;
    if (cfg_byp[d] && we1_s && a1_s == ra) return d1_s;
    if (cfg_byp[d] && we0_s && a0_s == ra) return d0_s;
    known = mem_v[d][ra];
    return mem_m[d][ra];
  endfunction

  function automatic void model_edge(input int d);
    bit busy_m = (clr_left[d] > 0);
    bit w0 = we0_s && !(cfg_zero[d] && a0_s == 4'd0);
    bit w1 = we1_s && !(cfg_zero[d] && a1_s == 4'd0);
    if (busy_m) begin
      int idx = 16 - clr_left[d];
      mem_m[d][idx] = 16'h0;
      mem_v[d][idx] = 1'b1;
      clr_left[d]--;
      conf_m[d] = 1'b0;
    end else begin
      conf_m[d] = w0 && w1 && (a0_s == a1_s);
      if (w0) begin mem_m[d][a0_s] = d0_s; mem_v[d][a0_s] = 1'b1; end
      if (w1) begin mem_m[d][a1_s] = d1_s; mem_v[d][a1_s] = 1'b1; end
      if (clr_s) clr_left[d] = 16;
    end
    if (rst_s) begin
      conf_m[d]   = 1'b0;
      clr_left[d] = cfg_clr[d] ? 16 : 0;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic drive();
    reset = rst_s;
    bus_a.clear_req = clr_s; bus_b.clear_req = clr_s;
    bus_a.we0 = we0_s; bus_a.waddr0 = a0_s; bus_a.wdata0 = d0_s;
    bus_b.we0 = we0_s; bus_b.waddr0 = a0_s; bus_b.wdata0 = d0_s;
    bus_a.we1 = we1_s; bus_a.waddr1 = a1_s; bus_a.wdata1 = d1_s;
    bus_b.we1 = we1_s; bus_b.waddr1 = a1_s; bus_b.wdata1 = d1_s;
    bus_a.raddr = {ra_s[2], ra_s[1], ra_s[0]};
    bus_b.raddr = {ra_s[3], ra_s[2], ra_s[1], ra_s[0]};
  endtask

  task automatic step();
    drive();
    if (model_live) begin
      for (int d = 0; d < 2; d++) begin
        push(d*16 + 8, {15'd0, clr_left[d] > 0});
        push(d*16 + 9, {15'd0, conf_m[d]});
        for (int k = 0; k < cfg_nread[d]; k++) begin
          bit kn;
          logic [15:0] v = model_read(d, ra_s[k], kn);
          if (kn) push(d*16 + k, v);
        end
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    if (rst_s) model_live = 1'b1;
    #1;
  endtask

  task automatic idle();
    rst_s = 1'b0; clr_s = 1'b0; we0_s = 1'b0; we1_s = 1'b0;
  endtask

  task automatic write0(input logic [3:0] a, input logic [15:0] v);
    idle(); we0_s = 1'b1; a0_s = a; d0_s = v;
  endtask

  task automatic read_all(input logic [3:0] a);
    for (int k = 0; k < 4; k++) ra_s[k] = a;
  endtask

  task automatic rand_reads();
    for (int k = 0; k < 4; k++) ra_s[k] = 4'($urandom_range(0, 15));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      idle(); rand_reads(); step();
    end
  endtask

  task automatic wait_not_busy(input int max_cycles);
    int n = 0;
    while ((bus_a.busy || bus_b.busy) && n < max_cycles) begin
      idle(); rand_reads(); step();
      n++;
    end
    checks++;
    if (bus_a.busy || bus_b.busy) begin
      errors++;
      $display("FAIL timeout: busy still high after %0d cycles (t=%0t)", max_cycles, $time);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      clr_left[d] = 0; conf_m[d] = 1'b0;
      for (int r = 0; r < 16; r++) begin mem_m[d][r] = 16'h0; mem_v[d][r] = 1'b0; end
    end
    idle(); a0_s = '0; a1_s = '0; d0_s = '0; d1_s = '0; read_all(4'd0);
    drive();
    @(posedge clk); #1;

    // reset sweep on dut_a; clear_req mid-sweep starts dut_b but must not restart dut_a
    idle(); rst_s = 1'b1; step();
    check_val("reset dut_a.busy", {15'd0, bus_a.busy}, 16'h0001);
    check_val("reset dut_b.busy", {15'd0, bus_b.busy}, 16'h0000);
    check_val("reset dut_a.wr_conflict", {15'd0, bus_a.wr_conflict}, 16'h0000);
    check_val("reset dut_b.wr_conflict", {15'd0, bus_b.wr_conflict}, 16'h0000);
    idle_steps(2);
    idle(); clr_s = 1'b1; rand_reads(); step();
    idle_steps(20);
    wait_not_busy(4);

    // same-cycle bypass, then the committed value
    write0(4'd3, 16'hBEEF); read_all(4'd3); step();
    idle(); read_all(4'd3); step();

    // colliding writes: port 1 wins and flags a conflict; r0 collision is silent on dut_a
    idle(); we0_s = 1'b1; we1_s = 1'b1; a0_s = 4'd5; a1_s = 4'd5;
    d0_s = 16'h1111; d1_s = 16'h2222; read_all(4'd5); step();
    idle(); read_all(4'd5); step();
    idle(); we0_s = 1'b1; we1_s = 1'b1; a0_s = 4'd0; a1_s = 4'd0;
    d0_s = 16'h3333; d1_s = 16'h4444; read_all(4'd0); step();
    idle(); read_all(4'd0); step();

    // plain r0 on dut_b; no-bypass read sees the old value
    write0(4'd0, 16'h0042); read_all(4'd0); step();
    idle(); read_all(4'd0); step();
    write0(4'd9, 16'h7777); read_all(4'd9); step();
    idle(); read_all(4'd9); step();

    // clear sweep drops a write issued mid-sweep
    write0(4'd7, 16'hA5A5); read_all(4'd7); step();
    write0(4'd2, 16'h5A5A); step();
    idle(); clr_s = 1'b1; read_all(4'd7); step();
    idle_steps(3);
    write0(4'd2, 16'h1234); read_all(4'd2); step();
    idle_steps(14);
    idle(); ra_s[0] = 4'd7; ra_s[1] = 4'd2; ra_s[2] = 4'd7; ra_s[3] = 4'd2; step();

    // reset mid-sweep restarts dut_a's sweep; extra clear_req is ignored
    idle(); clr_s = 1'b1; step();
    idle_steps(7);
    idle(); rst_s = 1'b1; rand_reads(); step();
    idle_steps(5);
    idle(); clr_s = 1'b1; rand_reads(); step();
    idle_steps(14);

    // randomised traffic with occasional clears and resets
    for (int i = 0; i < 800; i++) begin
      rst_s = ($urandom_range(0, 299) == 0);
      clr_s = ($urandom_range(0, 59) == 0);
      we0_s = !rst_s && ($urandom_range(0, 2) != 0);
      we1_s = !rst_s && ($urandom_range(0, 2) == 0);
      a0_s  = 4'($urandom_range(0, 15));
      a1_s  = ($urandom_range(0, 3) == 0) ? a0_s : 4'($urandom_range(0, 15));
      d0_s  = 16'($urandom);
      d1_s  = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       ra_s[k] = a0_s;
          1:       ra_s[k] = a1_s;
          default: ra_s[k] = 4'($urandom_range(0, 15));
        endcase
      end
      step();
    end
    idle(); drive();

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
